myproject_mul_pipe: RTL and testbench

Parametrised, pipelined fixed-point multiplier for the generated dense/conv datapaths. It replaces fixed-latency combinational multiplier cores where timing closure needs registered stages or where downstream logic can stall. It adds per-operand signedness, optional rounding shift, output saturation and a valid/ready handshake with backpressure. It computes `dout = resize((din0 * din1 + bias) >>> SHIFT)` at one result per cycle.

---
 rtl/myproject_mul_pipe.sv | 141 ++++++++++++++
 tb/tb_myproject_mul_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/myproject_mul_pipe.sv
// Pipelined fixed-point multiplier: dout = resize((din0 * din1 + bias) >>> SHIFT).
// Per-operand signedness, optional round/saturate, valid/ready with a global stall enable.
module myproject_mul_pipe #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 2,
  parameter int din0_WIDTH  = 14,
  parameter int din1_WIDTH  = 12,
  parameter int dout_WIDTH  = 26,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int ROUND       = 0,
  parameter int SATURATE    = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int AW       = din0_WIDTH + 1;
  localparam int BW       = din1_WIDTH + 1;
  localparam int P        = AW + BW;
  localparam int RW       = P + 1;
  localparam int BIAS_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] BIAS =
    (ROUND != 0 && SHIFT > 0) ? (RW'(1) << BIAS_POS) : '0;

  logic                 en;
  logic [NUM_STAGE-1:0] vq;

  logic signed [AW-1:0] a_d, a_s;
  logic signed [BW-1:0] b_d, b_s;
  logic signed [P-1:0]  p_d, p_s;
  logic signed [RW-1:0] pb, r_d, r_s;
  logic [dout_WIDTH-1:0] res;
  logic                  res_ovf;

  assign en        = ~vq[NUM_STAGE-1] | out_ready;
  assign in_ready  = en;
  assign out_valid = vq[NUM_STAGE-1];

  // Valid bits shift in lock-step with the data stages; bubbles travel as zeros.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vq <= '0;
    end else if (en) begin
      vq <= NUM_STAGE'({vq, in_valid});
    end
  end

  assign a_d = {(DIN0_SIGNED != 0) & din0[din0_WIDTH-1], din0};
  assign b_d = {(DIN1_SIGNED != 0) & din1[din1_WIDTH-1], din1};

  if (NUM_STAGE >= 2) begin : g_op_reg
    logic signed [AW-1:0] a_q;
    logic signed [BW-1:0] b_q;
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        a_q <= '0;
        b_q <= '0;
      end else if (en) begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
    assign a_s = a_q;
    assign b_s = b_q;
  end else begin : g_op_comb
    assign a_s = a_d;
    assign b_s = b_d;
  end

  assign p_d = P'(a_s) * P'(b_s);

  if (NUM_STAGE >= 3) begin : g_prod_reg
    logic signed [P-1:0] p_q;
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        p_q <= '0;
      end else if (en) begin
        p_q <= p_d;
      end
    end
    assign p_s = p_q;
  end else begin : g_prod_comb
    assign p_s = p_d;
  end

  // One extra bit of headroom so the rounding bias can never wrap.
  assign pb  = RW'(p_s) + BIAS;
  assign r_d = pb >>> SHIFT;

  if (NUM_STAGE >= 4) begin : g_shift_reg
    logic signed [RW-1:0] r_q;
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        r_q <= '0;
      end else if (en) begin
        r_q <= r_d;
      end
    end
    assign r_s = r_q;
  end else begin : g_shift_comb
    assign r_s = r_d;
  end

  // In range exactly when every bit from the output sign bit upward agrees.
  if (RW > dout_WIDTH) begin : g_resize
    logic [RW-dout_WIDTH:0] top;
    always_comb begin
      top     = r_s[RW-1:dout_WIDTH-1];
      res_ovf = ~((&top) | ~(|top));
      res     = r_s[dout_WIDTH-1:0];
      if (res_ovf && SATURATE != 0) begin
        res = r_s[RW-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                        : {1'b0, {(dout_WIDTH-1){1'b1}}};
      end
    end
  end else begin : g_fit
    assign res     = dout_WIDTH'(r_s);
    assign res_ovf = 1'b0;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout <= '0;
      ovf  <= 1'b0;
    end else if (en) begin
      dout <= res;
      ovf  <= res_ovf;
    end
  end

endmodule

// File: tb/tb_myproject_mul_pipe.sv
// Directed bench for myproject_mul_pipe: parameter variants, backpressure, mid-stream reset
// and a NUM_STAGE 1..4 sweep, all checked against hand-computed values.
module tb_myproject_mul_pipe;

  localparam int NI = 13;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  logic [13:0] din0;
  logic [11:0] din1;
  logic [NI-1:0] iv, ordy, ir_a, ov_a, ovf_a;
  logic [NI-1:0][25:0] dout_a;
  logic [15:0] d16_sat, d16_wrap;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 ap_clk = ~ap_clk;

  myproject_mul_pipe u_def (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[0]), .in_ready(ir_a[0]),
    .din0(din0), .din1(din1), .out_valid(ov_a[0]), .out_ready(ordy[0]),
    .dout(dout_a[0]), .ovf(ovf_a[0]));

  myproject_mul_pipe #(.dout_WIDTH(16), .SATURATE(1)) u_sat (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[1]), .in_ready(ir_a[1]),
    .din0(din0), .din1(din1), .out_valid(ov_a[1]), .out_ready(ordy[1]),
    .dout(d16_sat), .ovf(ovf_a[1]));
  assign dout_a[1] = {{10{d16_sat[15]}}, d16_sat};

  myproject_mul_pipe #(.dout_WIDTH(16), .SATURATE(0)) u_wrap (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[2]), .in_ready(ir_a[2]),
    .din0(din0), .din1(din1), .out_valid(ov_a[2]), .out_ready(ordy[2]),
    .dout(d16_wrap), .ovf(ovf_a[2]));
  assign dout_a[2] = {{10{d16_wrap[15]}}, d16_wrap};

  myproject_mul_pipe #(.SHIFT(4), .ROUND(1), .DIN1_SIGNED(1)) u_rnd1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[3]), .in_ready(ir_a[3]),
    .din0(din0), .din1(din1), .out_valid(ov_a[3]), .out_ready(ordy[3]),
    .dout(dout_a[3]), .ovf(ovf_a[3]));

  myproject_mul_pipe #(.SHIFT(4), .ROUND(0), .DIN1_SIGNED(1)) u_rnd0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[4]), .in_ready(ir_a[4]),
    .din0(din0), .din1(din1), .out_valid(ov_a[4]), .out_ready(ordy[4]),
    .dout(dout_a[4]), .ovf(ovf_a[4]));

  // Sweep instances: index 5 + 2*(ns-1) + sg; sg=0 unsigned x unsigned, sg=1 signed x signed.
  for (genvar ns = 1; ns <= 4; ns++) begin : g_ns
    for (genvar sg = 0; sg <= 1; sg++) begin : g_sg
      localparam int K = 5 + (ns - 1) * 2 + sg;
      myproject_mul_pipe #(.NUM_STAGE(ns), .DIN0_SIGNED(sg), .DIN1_SIGNED(sg)) u_dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[K]), .in_ready(ir_a[K]),
        .din0(din0), .din1(din1), .out_valid(ov_a[K]), .out_ready(ordy[K]),
        .dout(dout_a[K]), .ovf(ovf_a[K]));
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sdout(input int k);
    return longint'($signed(dout_a[k]));
  endfunction

  // Default configuration: signed 14-bit times unsigned 12-bit always fits 26 bits.
  function automatic longint model_def(input logic [13:0] a, input logic [11:0] b);
    longint x0, x1;
    x0 = longint'($signed(a));
    x1 = longint'(b);
    return x0 * x1;
  endfunction

  // Called at #1 after a rising edge; returns at the same phase after the result drained.
  task automatic run_one(input string tag, input int k, input logic [13:0] a,
                         input logic [11:0] b, input longint exp_d, input bit exp_o,
                         input int exp_lat);
    int lat;
    din0  = a;
    din1  = b;
    iv[k] = 1'b1;
    check({tag, ".in_ready"}, longint'(ir_a[k]), 1);
    @(posedge ap_clk); #1;
    iv[k] = 1'b0;
    lat   = 1;
    while (!ov_a[k] && lat < 8) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".dout"}, sdout(k), exp_d);
    check({tag, ".ovf"}, longint'(ovf_a[k]), longint'(exp_o));
    @(posedge ap_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [13:0] pa [8];
    logic [11:0] pb [8];
    longint exp_q[$];
    longint held;
    bit     held_ok;
    int     sent, rcv, seen;

    ap_rst_n = 1'b0;
    iv       = '0;
    ordy     = '1;
    din0     = '0;
    din1     = '0;
    #3;
    check("rst.out_valid", longint'(ov_a[0]), 0);
    check("rst.dout", sdout(0), 0);
    check("rst.ovf", longint'(ovf_a[0]), 0);
    check("rst.in_ready", longint'(ir_a[0]), 1);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    run_one("def", 0, 14'h2000, 12'd4095, -33546240, 1'b0, 2);
    run_one("sat", 1, 14'd100, 12'd1000, 32767, 1'b1, 2);
    run_one("wrap", 2, 14'd100, 12'd1000, -31072, 1'b1, 2);
    run_one("rnd1_pos", 3, 14'd3, 12'd3, 1, 1'b0, 2);
    run_one("rnd0_pos", 4, 14'd3, 12'd3, 0, 1'b0, 2);
    run_one("rnd1_neg", 3, 14'h3FF9, 12'd1, 0, 1'b0, 2);
    run_one("rnd0_neg", 4, 14'h3FF9, 12'd1, -1, 1'b0, 2);

    for (int ns = 1; ns <= 4; ns++) begin
      int u;
      u = 5 + (ns - 1) * 2;
      run_one($sformatf("sw%0d.uu_small", ns), u, 14'd3, 12'd5, 15, 1'b0, ns);
      run_one($sformatf("sw%0d.uu_max", ns), u, 14'h3FFF, 12'hFFF, -20479, 1'b1, ns);
      run_one($sformatf("sw%0d.ss_small", ns), u + 1, 14'h3FFD, 12'd7, -21, 1'b0, ns);
      run_one($sformatf("sw%0d.ss_minmin", ns), u + 1, 14'h2000, 12'h800, 16777216, 1'b0, ns);
      run_one($sformatf("sw%0d.ss_maxmin", ns), u + 1, 14'h1FFF, 12'h800, -16775168, 1'b0, ns);
    end

    // Backpressure: 8 back-to-back samples, out_ready low for cycles 4..6.
    for (int i = 0; i < 8; i++) begin
      pa[i] = 14'($urandom);
      pb[i] = 12'($urandom);
      exp_q.push_back(model_def(pa[i], pb[i]));
    end
    sent    = 0;
    rcv     = 0;
    held    = 0;
    held_ok = 1'b0;
    for (int t = 0; t < 40 && rcv < 8; t++) begin
      ordy[0] = !(t >= 4 && t <= 6);
      iv[0]   = (sent < 8);
      if (sent < 8) begin
        din0 = pa[sent];
        din1 = pb[sent];
      end
      @(negedge ap_clk);
      if (ov_a[0] && ordy[0]) begin
        check($sformatf("bp.dout%0d", rcv), sdout(0), exp_q[rcv]);
        check($sformatf("bp.ovf%0d", rcv), longint'(ovf_a[0]), 0);
        rcv++;
        held_ok = 1'b0;
      end else if (ov_a[0]) begin
        check("bp.stall_in_ready", longint'(ir_a[0]), 0);
        if (held_ok) check("bp.hold", sdout(0), held);
        held    = sdout(0);
        held_ok = 1'b1;
      end
      if (iv[0] && ir_a[0]) sent++;
      @(posedge ap_clk); #1;
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    check("bp.count", rcv, 8);
    repeat (2) @(posedge ap_clk);
    #1;

    // Mid-stream reset: one held result in u_wrap, three samples inside the NUM_STAGE=4 pipe.
    ordy[2] = 1'b0;
    din0    = 14'd100;
    din1    = 12'd1000;
    iv[2]   = 1'b1;
    @(posedge ap_clk); #1;
    iv[2]  = 1'b0;
    iv[12] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din0 = 14'(i + 1);
      din1 = 12'(i + 2);
      @(posedge ap_clk); #1;
    end
    iv[12] = 1'b0;
    check("rst_mid.pre_held", longint'(ov_a[2]), 1);
    @(negedge ap_clk) ap_rst_n = 1'b0;
    #1;
    check("rst_mid.out_valid", longint'(ov_a[2]), 0);
    check("rst_mid.dout", sdout(2), 0);
    check("rst_mid.ovf", longint'(ovf_a[2]), 0);
    check("rst_mid.in_ready", longint'(ir_a[2]), 1);
    check("rst_mid.ns4_valid", longint'(ov_a[12]), 0);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    ordy[2] = 1'b1;
    seen    = 0;
    repeat (8) begin
      @(posedge ap_clk); #1;
      if (ov_a[12] || ov_a[2]) seen++;
    end
    check("rst_mid.ghost", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
